bytestuffer: RTL and testbench

JPEG entropy-coded-segment byte stuffer. It sits after the Huffman/bit-packer stage and before the output byte sink. Every input byte is passed through in order; after each 0xFF byte it inserts one 0x00 byte. An internal FIFO absorbs the rate mismatch, because one input byte can produce two output bytes.

---
 rtl/bytestuffer.sv | 104 ++++++++++
 tb/tb_bytestuffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bytestuffer.sv
`default_nettype none
// ============================================================================
// Module      : bytestuffer
// Description : JPEG entropy-coded-segment byte stuffer. Every input byte is
//               forwarded in order and a 0x00 is inserted after each 0xFF.
//               An input FIFO absorbs the 1:2 rate expansion caused by stuffing.
//               Optional macro BYTESTUFFER_LEVEL_EN adds the fifo_level port.
// Revision    : 1.0 - initial release
// ============================================================================
module bytestuffer #(
    parameter int FIFO_DEPTH = 512
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       data_in_valid,
    input  logic [7:0] data_in,
    output logic       data_out_valid,
    output logic [7:0] data_out,
    output logic       overflow
`ifdef BYTESTUFFER_LEVEL_EN
    ,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`endif
);

    localparam int              c_PW   = $clog2(FIFO_DEPTH);
    localparam logic [c_PW:0]   c_FULL = (c_PW + 1)'(FIFO_DEPTH);

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_PW:0]   r_count;
    logic            r_stuff_pending;
    logic            r_data_out_valid;
    logic [7:0]      r_data_out;
    logic            r_overflow;

    logic [7:0]      w_head;
    logic            w_pop;
    logic            w_push;

    // A stuff cycle takes the output slot, so nothing is popped while one is owed.
    assign w_head = r_mem[r_rd_ptr];
    assign w_pop  = !r_stuff_pending && (r_count != '0);
    assign w_push = data_in_valid && ((r_count != c_FULL) || w_pop);

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_stuff_pending  <= 1'b0;
            r_data_out_valid <= 1'b0;
            r_data_out       <= 8'h00;
            r_overflow       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            if (data_in_valid && !w_push) begin
                r_overflow <= 1'b1;
            end

            if (r_stuff_pending) begin
                r_data_out       <= 8'h00;
                r_data_out_valid <= 1'b1;
                r_stuff_pending  <= 1'b0;
            end else if (w_pop) begin
                r_data_out       <= w_head;
                r_data_out_valid <= 1'b1;
                r_stuff_pending  <= (w_head == 8'hFF);
            end else begin
                r_data_out_valid <= 1'b0;
            end
        end
    end

    assign data_out_valid = r_data_out_valid;
    assign data_out       = r_data_out;
    assign overflow       = r_overflow;

`ifdef BYTESTUFFER_LEVEL_EN
    assign fifo_level = r_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bytestuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bytestuffer
// Description : Self-checking bench for bytestuffer: directed cases, a random
//               stream against a queue model, mid-stream reset and overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bytestuffer;

    logic       clock  = 1'b0;
    logic       nreset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       out_valid;
    logic [7:0] out_data;
    logic       ovf;

    logic       in4_valid = 1'b0;
    logic [7:0] in4_data  = 8'h00;
    logic       out4_valid;
    logic [7:0] out4_data;
    logic       ovf4;

`ifdef BYTESTUFFER_LEVEL_EN
    logic [9:0] level;
    logic [2:0] level4;
`endif

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q [$];
    logic [7:0] q4    [$];

    always #5 clock = ~clock;

    bytestuffer #(.FIFO_DEPTH(512)) u_dut (
        .clock          (clock),
        .nreset         (nreset),
        .data_in_valid  (in_valid),
        .data_in        (in_data),
        .data_out_valid (out_valid),
        .data_out       (out_data),
        .overflow       (ovf)
`ifdef BYTESTUFFER_LEVEL_EN
        ,
        .fifo_level     (level)
`endif
    );

    bytestuffer #(.FIFO_DEPTH(4)) u_dut4 (
        .clock          (clock),
        .nreset         (nreset),
        .data_in_valid  (in4_valid),
        .data_in        (in4_data),
        .data_out_valid (out4_valid),
        .data_out       (out4_data),
        .overflow       (ovf4)
`ifdef BYTESTUFFER_LEVEL_EN
        ,
        .fifo_level     (level4)
`endif
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: the expected output is the input stream with 00 after every FF.
    task automatic push512(input logic [7:0] b);
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        exp_q.push_back(b);
        if (b == 8'hFF) exp_q.push_back(8'h00);
    endtask

    task automatic idle512();
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    always @(negedge clock) begin
        if (nreset && out_valid) begin
            if (exp_q.size() == 0) check_value("exp_available", 32'(exp_q.size()), 32'd1);
            else                   check_value("stream", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
        end
    end

    always @(negedge clock) begin
        if (nreset && out4_valid) q4.push_back(out4_data);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp3 [7];
        int ffpct;
        int gap;
        logic [7:0] b;

        // Reset state
        repeat (3) @(negedge clock);
        #1;
        check_value("rst_valid", out_valid, 0);
        check_value("rst_data", out_data, 0);
        check_value("rst_ovf", ovf, 0);
        check_value("rst_ovf4", ovf4, 0);
`ifdef BYTESTUFFER_LEVEL_EN
        check_value("rst_level", level, 0);
`endif
        nreset = 1'b1;
        idle512();

        // Two plain bytes: first valid cycle follows the edge after the push
        push512(8'h12);
        @(negedge clock); #1;
        check_value("lat_early", out_valid, 0);
        in_valid = 1'b1; in_data = 8'h34; exp_q.push_back(8'h34);
        @(negedge clock); #1;
        check_value("t1_v0", out_valid, 1);
        check_value("t1_d0", out_data, 8'h12);
        in_valid = 1'b0;
        @(negedge clock); #1;
        check_value("t1_v1", out_valid, 1);
        check_value("t1_d1", out_data, 8'h34);
        check_value("t1_ovf", ovf, 0);
        repeat (3) idle512();

        // Single FF then idle
        push512(8'hFF);
        idle512();
        @(negedge clock); #1;
        check_value("t2_v0", out_valid, 1);
        check_value("t2_d0", out_data, 8'hFF);
        @(negedge clock); #1;
        check_value("t2_v1", out_valid, 1);
        check_value("t2_d1", out_data, 8'h00);
        @(negedge clock); #1;
        check_value("t2_idle", out_valid, 0);
        repeat (3) idle512();

        // Back-to-back FF FF 00 FF, no gaps once output starts
        exp3 = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
        fork
            begin
                push512(8'hFF); push512(8'hFF); push512(8'h00); push512(8'hFF);
                idle512();
            end
            begin
                int n = 0;
                int guard = 0;
                bit started = 0;
                bit gapped = 0;
                while (n < 7 && guard < 20 && !gapped) begin
                    @(negedge clock); #1;
                    guard++;
                    if (out_valid) begin
                        check_value("t3_byte", out_data, exp3[n]);
                        n++;
                        started = 1;
                    end else if (started) begin
                        check_value("t3_nogap", out_valid, 1);
                        gapped = 1;
                    end
                end
                check_value("t3_count", n, 7);
            end
        join
        repeat (4) idle512();

        // Random stream with swept FF probability and geometric idle gaps (mean 1)
        for (int i = 0; i < 10000; i++) begin
            ffpct = (i * 50) / 9999;
            if (int'($urandom_range(99, 0)) < ffpct) b = 8'hFF;
            else                                   b = 8'($urandom_range(255, 0));
            push512(b);
            gap = 0;
            while ($urandom_range(1, 0) == 1 && gap < 20) begin
                idle512();
                gap++;
            end
        end
        idle512();
        repeat (513) @(negedge clock);
        #1;
        check_value("rand_drained", 32'(exp_q.size()), 0);
        check_value("rand_ovf", ovf, 0);

        // Reset while a stuff byte is owed
        push512(8'hFF);
        idle512();
        @(negedge clock); #1;
        check_value("mr_ff_valid", out_valid, 1);
        check_value("mr_ff_data", out_data, 8'hFF);
        nreset = 1'b0;
        exp_q.delete();
        @(negedge clock); #1;
        check_value("mr_valid", out_valid, 0);
        check_value("mr_data", out_data, 0);
        check_value("mr_ovf", ovf, 0);
        nreset = 1'b1;
        @(negedge clock); #1;
        check_value("mr_nostray", out_valid, 0);
        repeat (4) idle512();
        push512(8'h55);
        idle512();
        @(negedge clock); #1;
        check_value("mr_restart_v", out_valid, 1);
        check_value("mr_restart_d", out_data, 8'h55);
        repeat (4) idle512();
        check_value("mr_drained", 32'(exp_q.size()), 0);

        // Depth-4 instance: 16 consecutive FF pushes overflow the FIFO
        q4.delete();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clock);
            if (i == 9)  check_value("ovf4_before_full", ovf4, 0);
            if (i == 10) check_value("ovf4_rise", ovf4, 1);
            in4_valid = 1'b1;
            in4_data  = 8'hFF;
        end
        @(negedge clock);
        in4_valid = 1'b0;
        repeat (60) @(negedge clock);
        #1;
        check_value("ovf4_sticky", ovf4, 1);
        check_value("q4_len", 32'(q4.size()), 24);
        for (int i = 0; i < q4.size(); i++) begin
            check_value("q4_pair", q4[i], (i % 2 == 0) ? 32'hFF : 32'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
